w0rm_peripheral_arbiter: RTL
============================

# w0rm_peripheral_arbiter

Two-master arbiter for the W0RM peripheral memory bus: it shares one peripheral slave port (e.g. the GPIO peripheral) between two requesters. It serialises their accesses with round-robin priority, keeps one transaction outstanding at a time, and returns each response or timeout error to the master that issued it. It sits between the CPU/DMA bus masters and a peripheral's `mem_*` port, on the peripheral clock domain.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, address width.
- `DATA_WIDTH`, 8, data width.
- `TIMEOUT`, 16, number of WAIT cycles without a peripheral response before an error completion; must be ≥ 1.

Ports (x = 0, 1; per-master ports are replicated):
- `mem_clk`  in  1  single clock; all state changes on rising edge.
- `cpu_reset_n`  in  1  asynchronous, active-low reset.
- `mx_valid_i`  in  1  master x request; held high until `mx_ready_o` is seen.
- `mx_read_i`, `mx_write_i`  in  1 each  command; exactly one must be set.
- `mx_addr_i`  in  ADDR_WIDTH  request address.
- `mx_data_i`  in  DATA_WIDTH  write data.
- `mx_ready_o`  out  1  one-cycle pulse: request accepted.
- `mx_valid_o`  out  1  one-cycle pulse: completion for master x.
- `mx_data_o`  out  DATA_WIDTH  read data; valid with `mx_valid_o`, 0 otherwise.
- `mx_error_o`  out  1  with `mx_valid_o`: timeout or illegal command.
- `per_valid_o`, `per_read_o`, `per_write_o`  out  1 each  peripheral command strobe and type.
- `per_addr_o`  out  ADDR_WIDTH  peripheral address.
- `per_data_o`  out  DATA_WIDTH  peripheral write data.
- `per_valid_i`  in  1  peripheral response strobe.
- `per_data_i`  in  DATA_WIDTH  peripheral response data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, ERR. Reset state is IDLE.
- Priority register `prio` resets to 0, so master 0 is preferred.
- IDLE, when some `mx_valid_i` = 1:
  - If only one master requests, grant it.
  - If both request, grant master `prio`.
  - Latch the granted master's command, address and data; pulse its `mx_ready_o` in the next cycle.
  - Next state: ISSUE if exactly one of read/write is set; ERR otherwise (both or neither set).
- ISSUE: `per_valid_o` = 1 for exactly one cycle, with the latched `per_read_o`, `per_write_o`, `per_addr_o` and `per_data_o`. Clear the timeout counter; next state WAIT.
- WAIT:
  - On `per_valid_i` = 1: pulse the granted master's `mx_valid_o`, set `mx_data_o` = `per_data_i` (0 for writes), `mx_error_o` = 0. Go to IDLE.
  - If the counter reaches TIMEOUT with no response: pulse `mx_valid_o` with `mx_data_o` = 0 and `mx_error_o` = 1. Go to IDLE.
  - If `per_valid_i` and timeout occur in the same cycle, the response wins.
- ERR: pulse `mx_valid_o` with `mx_error_o` = 1 and `mx_data_o` = 0. Go to IDLE. No peripheral access is issued.
- On every completion, including errors, `prio` is set to the master that was not granted.
- `per_valid_i` outside WAIT is ignored and discarded.
- Timeout counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.
- `per_*_o` command fields hold their latched values between transactions. `per_valid_o` is the only qualifier.

## Timing
- All outputs are registered.
- Reset values: every `mx_*_o` = 0, every `per_*_o` = 0, state IDLE, `prio` = 0.
- Reset asserted mid-transaction aborts it asynchronously: the in-flight completion is never delivered, and a late `per_valid_i` is ignored.
- Request sampled in IDLE at edge E0. Cycle after E0: `mx_ready_o` = 1 and `per_valid_o` = 1.
- If the peripheral answers in the cycle right after ISSUE, `mx_valid_o` is high two cycles after `mx_ready_o`. Minimum request-to-completion is 3 cycles.
- A timeout completion is high TIMEOUT+1 cycles after the ISSUE cycle.
- An illegal command completes one cycle after `mx_ready_o`.
- The cycle carrying `mx_valid_o` is in IDLE and may accept the next request, so back-to-back grants are possible.
- After seeing `mx_ready_o`, a master must drop or replace its request. Acceptance cannot repeat before completion.

## Test plan
- Master 0 reads address 0x02 alone; peripheral returns 0xA5 one cycle after ISSUE -> `m0_ready_o` at cycle 1, one `per_valid_o` pulse with read=1 and addr=0x02, `m0_valid_o` with data 0xA5 at cycle 3, error 0; master 1 outputs stay 0.
- Both masters request continuously, 4 writes each -> grants alternate 0,1,0,1,…; each master gets exactly 4 completions; `per_valid_o` never asserts during WAIT.
- Peripheral never responds, TIMEOUT=16 -> `m1_valid_o` with `m1_error_o` = 1 and data 0x00 exactly 17 cycles after ISSUE; the next request is then served normally.
- `m0_read_i` = `m0_write_i` = 1 -> `m0_ready_o`, then `m0_error_o` pulse one cycle later; no `per_valid_o` pulse.
- `per_valid_i` on the same edge the counter reaches TIMEOUT -> completion with data and error = 0. A stray `per_valid_i` during IDLE -> no `mx_valid_o`.
- `cpu_reset_n` dropped during WAIT, then released -> all outputs 0 immediately; late `per_valid_i` ignored; first grant after release goes to master 0 when both request.

Source files
------------

// File: rtl/w0rm_peripheral_arbiter_if.sv
// Bus bundle between two W0RM masters, the arbiter and one peripheral mem_* port.
// Signal suffixes are from the arbiter's point of view.
interface w0rm_peripheral_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  m0_valid_i, m0_read_i, m0_write_i;
  logic [ADDR_WIDTH-1:0] m0_addr_i;
  logic [DATA_WIDTH-1:0] m0_data_i;
  logic                  m0_ready_o, m0_valid_o, m0_error_o;
  logic [DATA_WIDTH-1:0] m0_data_o;

  logic                  m1_valid_i, m1_read_i, m1_write_i;
  logic [ADDR_WIDTH-1:0] m1_addr_i;
  logic [DATA_WIDTH-1:0] m1_data_i;
  logic                  m1_ready_o, m1_valid_o, m1_error_o;
  logic [DATA_WIDTH-1:0] m1_data_o;

  logic                  per_valid_o, per_read_o, per_write_o;
  logic [ADDR_WIDTH-1:0] per_addr_o;
  logic [DATA_WIDTH-1:0] per_data_o;
  logic                  per_valid_i;
  logic [DATA_WIDTH-1:0] per_data_i;

  // Arbiter side.
  modport slave (
    input  m0_valid_i, m0_read_i, m0_write_i, m0_addr_i, m0_data_i,
    output m0_ready_o, m0_valid_o, m0_error_o, m0_data_o,
    input  m1_valid_i, m1_read_i, m1_write_i, m1_addr_i, m1_data_i,
    output m1_ready_o, m1_valid_o, m1_error_o, m1_data_o,
    output per_valid_o, per_read_o, per_write_o, per_addr_o, per_data_o,
    input  per_valid_i, per_data_i
  );

  // Environment side: requesters plus the peripheral.
  modport master (
    output m0_valid_i, m0_read_i, m0_write_i, m0_addr_i, m0_data_i,
    input  m0_ready_o, m0_valid_o, m0_error_o, m0_data_o,
    output m1_valid_i, m1_read_i, m1_write_i, m1_addr_i, m1_data_i,
    input  m1_ready_o, m1_valid_o, m1_error_o, m1_data_o,
    input  per_valid_o, per_read_o, per_write_o, per_addr_o, per_data_o,
    output per_valid_i, per_data_i
  );
endinterface

// File: rtl/w0rm_peripheral_arbiter.sv
// Round-robin two-master arbiter for a single W0RM peripheral port, one
// transaction outstanding, with a response timeout and illegal-command error.
module w0rm_peripheral_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input logic                        mem_clk,
  input logic                        cpu_reset_n,
  w0rm_peripheral_arbiter_if.slave   bus
);
  localparam int             CW  = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TMO = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_e;

  state_e                          state_q, state_d;
  logic                            prio_q, prio_d, gnt_q, gnt_d, sel;
  logic [CW-1:0]                   cnt_q, cnt_d, cnt_inc;
  logic [1:0]                      req, rd, wr;
  logic [1:0][ADDR_WIDTH-1:0]      addr;
  logic [1:0][DATA_WIDTH-1:0]      wdata;
  logic [1:0]                      rdy_q, rdy_d, val_q, val_d, err_q, err_d;
  logic [1:0][DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic                            per_valid_q, per_valid_d;
  logic                            per_read_q, per_read_d, per_write_q, per_write_d;
  logic [ADDR_WIDTH-1:0]           per_addr_q, per_addr_d;
  logic [DATA_WIDTH-1:0]           per_data_q, per_data_d;

  assign req   = {bus.m1_valid_i, bus.m0_valid_i};
  assign rd    = {bus.m1_read_i,  bus.m0_read_i};
  assign wr    = {bus.m1_write_i, bus.m0_write_i};
  assign addr  = {bus.m1_addr_i,  bus.m0_addr_i};
  assign wdata = {bus.m1_data_i,  bus.m0_data_i};

  assign bus.m0_ready_o  = rdy_q[0];
  assign bus.m0_valid_o  = val_q[0];
  assign bus.m0_error_o  = err_q[0];
  assign bus.m0_data_o   = rdata_q[0];
  assign bus.m1_ready_o  = rdy_q[1];
  assign bus.m1_valid_o  = val_q[1];
  assign bus.m1_error_o  = err_q[1];
  assign bus.m1_data_o   = rdata_q[1];
  assign bus.per_valid_o = per_valid_q;
  assign bus.per_read_o  = per_read_q;
  assign bus.per_write_o = per_write_q;
  assign bus.per_addr_o  = per_addr_q;
  assign bus.per_data_o  = per_data_q;

  // Saturating increment: the counter parks at TMO instead of wrapping.
  assign cnt_inc = (cnt_q == TMO) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    sel         = 1'b0;
    rdy_d       = '0;
    val_d       = '0;
    err_d       = '0;
    rdata_d     = '0;
    per_valid_d = 1'b0;
    per_read_d  = per_read_q;
    per_write_d = per_write_q;
    per_addr_d  = per_addr_q;
    per_data_d  = per_data_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          sel        = (req[0] & req[1]) ? prio_q : req[1];
          gnt_d      = sel;
          rdy_d[sel] = 1'b1;
          if (rd[sel] ^ wr[sel]) begin
            per_valid_d = 1'b1;
            per_read_d  = rd[sel];
            per_write_d = wr[sel];
            per_addr_d  = addr[sel];
            per_data_d  = wdata[sel];
            state_d     = ISSUE;
          end else begin
            state_d = ERR;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A response arriving on the timeout edge still completes normally.
        if (bus.per_valid_i) begin
          val_d[gnt_q]   = 1'b1;
          rdata_d[gnt_q] = per_read_q ? bus.per_data_i : '0;
          prio_d         = ~gnt_q;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO) begin
            val_d[gnt_q] = 1'b1;
            err_d[gnt_q] = 1'b1;
            prio_d       = ~gnt_q;
            state_d      = IDLE;
          end
        end
      end
      ERR: begin
        val_d[gnt_q] = 1'b1;
        err_d[gnt_q] = 1'b1;
        prio_d       = ~gnt_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mem_clk or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      gnt_q       <= 1'b0;
      cnt_q       <= '0;
      rdy_q       <= '0;
      val_q       <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      per_valid_q <= 1'b0;
      per_read_q  <= 1'b0;
      per_write_q <= 1'b0;
      per_addr_q  <= '0;
      per_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      rdy_q       <= rdy_d;
      val_q       <= val_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      per_valid_q <= per_valid_d;
      per_read_q  <= per_read_d;
      per_write_q <= per_write_d;
      per_addr_q  <= per_addr_d;
      per_data_q  <= per_data_d;
    end
  end
endmodule
